// File: rtl/id_scoreboard_pkg.sv
// rtl/id_scoreboard_pkg.sv - shared types and helpers for the decode-stage register scoreboard
package id_scoreboard_pkg;

  typedef enum logic [1:0] {
    SB_NONE  = 2'd0,
    SB_RAW   = 2'd1,
    SB_FULL  = 2'd2,
    SB_FLUSH = 2'd3
  } sb_stall_e;

  // Occupancy needs to represent 0..DEPTH inclusive.
  function automatic int sb_occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sb_pending_match.sv
// rtl/sb_pending_match.sv - compares one source address against every live writing entry
module sb_pending_match #(
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic [ADDR_WIDTH-1:0]            src,
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] dest,
  input  logic [DEPTH-1:0]                 live_we,
  input  logic [PTR_W-1:0]                 head,
  input  logic                             exclude_head,
  output logic                             match
);

  always_comb begin
    match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_we[i] && (dest[i] == src) && (src != '0) &&
          !(exclude_head && (PTR_W'(i) == head))) begin
        match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/id_scoreboard.sv
// rtl/id_scoreboard.sv - in-order in-flight destination tracker that stalls issue on RAW, full and flush
module id_scoreboard
  import id_scoreboard_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int DEPTH      = 4,
  parameter int WB_BYPASS  = 1,
  localparam int OCC_W     = sb_occ_width(DEPTH),
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid_ip,
  input  logic [ADDR_WIDTH-1:0] issue_src1_ip,
  input  logic [ADDR_WIDTH-1:0] issue_src2_ip,
  input  logic                  issue_src1_used_ip,
  input  logic                  issue_src2_used_ip,
  input  logic [ADDR_WIDTH-1:0] issue_dest_ip,
  input  logic                  issue_dest_we_ip,
  output logic                  issue_ready_op,
  output logic                  stall_op,
  output sb_stall_e             stall_reason_op,
  input  logic                  retire_valid_ip,
  input  logic [ADDR_WIDTH-1:0] retire_addr_ip,
  input  logic                  flush_ip,
  input  logic [OCC_W-1:0]      flush_keep_ip,
  output logic [OCC_W-1:0]      occupancy_op,
  output logic                  full_op,
  output logic                  empty_op,
  output logic                  error_op
);

  logic [DEPTH-1:0][ADDR_WIDTH-1:0] buf_dest;
  logic [DEPTH-1:0]                 buf_we;
  logic [PTR_W-1:0]                 head_q, tail_q, head_n, tail_n;
  logic [OCC_W-1:0]                 occ_q, occ_n, occ_after_retire;
  logic [DEPTH-1:0]                 live_we;
  logic                             match1, match2, raw, push, pop, exclude_head;

  assign occupancy_op = occ_q;
  assign full_op      = (occ_q == OCC_W'(DEPTH));
  assign empty_op     = (occ_q == '0);

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    live_we = '0;
    for (int i = 0; i < DEPTH; i++) begin
      live_we[i] = buf_we[i] && (OCC_W'(PTR_W'(PTR_W'(i) - head_q)) < occ_q);
    end
  end

  assign exclude_head = (WB_BYPASS != 0) && retire_valid_ip;

  sb_pending_match #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_match_src1 (
    .src(issue_src1_ip), .dest(buf_dest), .live_we(live_we), .head(head_q),
    .exclude_head(exclude_head), .match(match1)
  );

  sb_pending_match #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_match_src2 (
    .src(issue_src2_ip), .dest(buf_dest), .live_we(live_we), .head(head_q),
    .exclude_head(exclude_head), .match(match2)
  );

  assign raw            = (issue_src1_used_ip & match1) | (issue_src2_used_ip & match2);
  assign issue_ready_op = ~flush_ip & ~raw & (~full_op | retire_valid_ip);
  assign stall_op       = issue_valid_ip & ~issue_ready_op;

  always_comb begin
    stall_reason_op = SB_NONE;
    if (issue_valid_ip) begin
      if (flush_ip)                          stall_reason_op = SB_FLUSH;
      else if (raw)                          stall_reason_op = SB_RAW;
      else if (full_op && !retire_valid_ip)  stall_reason_op = SB_FULL;
    end
  end

  // A retire on an empty buffer only raises the error; it must not underflow.
  assign push             = issue_valid_ip & issue_ready_op;
  assign pop              = retire_valid_ip & ~empty_op;
  assign head_n           = head_q + PTR_W'(pop);
  assign occ_after_retire = occ_q - OCC_W'(pop);

  always_comb begin
    occ_n  = occ_after_retire + OCC_W'(push);
    tail_n = tail_q + PTR_W'(push);
    if (flush_ip) begin
      occ_n  = (flush_keep_ip < occ_after_retire) ? flush_keep_ip : occ_after_retire;
      tail_n = head_n + PTR_W'(occ_n);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_dest <= '0;
      buf_we   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      occ_q    <= '0;
      error_op <= 1'b0;
    end else begin
      if (push) begin
        buf_dest[tail_q] <= issue_dest_ip;
        buf_we[tail_q]   <= issue_dest_we_ip & (issue_dest_ip != '0);
      end
      head_q <= head_n;
      tail_q <= tail_n;
      occ_q  <= occ_n;
      if (retire_valid_ip &&
          (empty_op || (buf_we[head_q] && (retire_addr_ip != buf_dest[head_q])))) begin
        error_op <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// tb/tb_id_scoreboard.sv - directed self-checking bench for id_scoreboard
module tb_id_scoreboard;
  import id_scoreboard_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       issue_valid_ip, issue_src1_used_ip, issue_src2_used_ip, issue_dest_we_ip;
  logic [4:0] issue_src1_ip, issue_src2_ip, issue_dest_ip, retire_addr_ip;
  logic       issue_ready_op, stall_op, retire_valid_ip, flush_ip;
  sb_stall_e  stall_reason_op;
  logic [2:0] flush_keep_ip, occupancy_op;
  logic       full_op, empty_op, error_op;

  int errors = 0;
  int checks = 0;

  id_scoreboard dut (
    .clock(clock), .reset(reset),
    .issue_valid_ip(issue_valid_ip), .issue_src1_ip(issue_src1_ip), .issue_src2_ip(issue_src2_ip),
    .issue_src1_used_ip(issue_src1_used_ip), .issue_src2_used_ip(issue_src2_used_ip),
    .issue_dest_ip(issue_dest_ip), .issue_dest_we_ip(issue_dest_we_ip),
    .issue_ready_op(issue_ready_op), .stall_op(stall_op), .stall_reason_op(stall_reason_op),
    .retire_valid_ip(retire_valid_ip), .retire_addr_ip(retire_addr_ip),
    .flush_ip(flush_ip), .flush_keep_ip(flush_keep_ip),
    .occupancy_op(occupancy_op), .full_op(full_op), .empty_op(empty_op), .error_op(error_op)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    issue_valid_ip = 0; issue_src1_ip = 0; issue_src2_ip = 0;
    issue_src1_used_ip = 0; issue_src2_used_ip = 0;
    issue_dest_ip = 0; issue_dest_we_ip = 0;
    retire_valid_ip = 0; retire_addr_ip = 0; flush_ip = 0; flush_keep_ip = 0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input int dest, input bit we);
    idle();
    issue_valid_ip = 1; issue_dest_ip = 5'(dest); issue_dest_we_ip = we;
    step();
  endtask

  task automatic retire(input int addr);
    idle();
    retire_valid_ip = 1; retire_addr_ip = 5'(addr);
    step();
  endtask

  task automatic present(input int s1, input bit u1, input int s2, input bit u2);
    idle();
    issue_valid_ip = 1; issue_dest_ip = 5'd20; issue_dest_we_ip = 1;
    issue_src1_ip = 5'(s1); issue_src1_used_ip = u1;
    issue_src2_ip = 5'(s2); issue_src2_used_ip = u2;
    #1;
  endtask

  initial begin
    idle();
    step();
    reset = 0;
    #1;
    check("rst_occ", int'(occupancy_op), 0);
    check("rst_empty", int'(empty_op), 1);
    check("rst_full", int'(full_op), 0);
    check("rst_err", int'(error_op), 0);
    check("rst_ready", int'(issue_ready_op), 1);
    check("rst_stall", int'(stall_op), 0);
    check("rst_reason", int'(stall_reason_op), int'(SB_NONE));

    // RAW stall released by a same-cycle retire through the bypass
    issue(5, 1);
    check("raw_occ1", int'(occupancy_op), 1);
    present(5, 1, 0, 0);
    check("raw_stall", int'(stall_op), 1);
    check("raw_reason", int'(stall_reason_op), int'(SB_RAW));
    retire_valid_ip = 1; retire_addr_ip = 5; #1;
    check("raw_bypass_ready", int'(issue_ready_op), 1);
    check("raw_bypass_stall", int'(stall_op), 0);
    step();
    check("raw_swap_occ", int'(occupancy_op), 1);
    retire(20);
    check("raw_drain_occ", int'(occupancy_op), 0);
    check("raw_err", int'(error_op), 0);

    // register 0 and unused sources
    issue(0, 1);
    present(0, 1, 0, 1);
    check("r0_stall", int'(stall_op), 0);
    issue(3, 1);
    present(0, 0, 3, 0);
    check("unused_stall", int'(stall_op), 0);
    present(0, 0, 3, 1);
    check("used_src2_stall", int'(stall_op), 1);
    retire(0);
    retire(3);
    check("r0_drain_occ", int'(occupancy_op), 0);

    // fill, full stall, pass-through, wrapped pending
    for (int i = 0; i < 4; i++) issue(10 + i, 1);
    check("full_occ", int'(occupancy_op), 4);
    check("full_flag", int'(full_op), 1);
    present(0, 0, 0, 0);
    check("full_reason", int'(stall_reason_op), int'(SB_FULL));
    check("full_stall", int'(stall_op), 1);
    issue_dest_ip = 14; retire_valid_ip = 1; retire_addr_ip = 10; #1;
    check("pass_ready", int'(issue_ready_op), 1);
    step();
    check("pass_occ", int'(occupancy_op), 4);
    present(14, 1, 0, 0);
    check("wrap_raw", int'(stall_reason_op), int'(SB_RAW));
    for (int i = 0; i < 4; i++) retire(11 + i);
    check("wrap_drain_occ", int'(occupancy_op), 0);
    check("wrap_err", int'(error_op), 0);

    // flush keeping the oldest entry, then flush combined with retire
    issue(1, 1); issue(2, 1); issue(3, 1);
    check("fl_occ3", int'(occupancy_op), 3);
    present(0, 0, 0, 0);
    flush_ip = 1; flush_keep_ip = 1; #1;
    check("fl_reason", int'(stall_reason_op), int'(SB_FLUSH));
    check("fl_stall", int'(stall_op), 1);
    step();
    check("fl_occ1", int'(occupancy_op), 1);
    present(2, 1, 3, 1);
    check("fl_unpend", int'(stall_op), 0);
    present(1, 1, 0, 0);
    check("fl_keep_pend", int'(stall_op), 1);
    idle();
    retire_valid_ip = 1; retire_addr_ip = 1; flush_ip = 1; flush_keep_ip = 1;
    step();
    check("fl_ret_occ", int'(occupancy_op), 0);
    check("fl_ret_empty", int'(empty_op), 1);
    check("fl_ret_err", int'(error_op), 0);

    // writeback-order errors
    retire(0);
    check("err_empty", int'(error_op), 1);
    idle(); step(); step();
    check("err_sticky", int'(error_op), 1);
    reset = 1; #1; reset = 0;
    check("err_cleared", int'(error_op), 0);
    issue(4, 1);
    retire(6);
    check("err_addr", int'(error_op), 1);

    // asynchronous reset mid-cycle
    issue(1, 1); issue(2, 1); issue(3, 1);
    check("ar_occ3", int'(occupancy_op), 3);
    idle();
    #2 reset = 1;
    #1;
    check("ar_occ", int'(occupancy_op), 0);
    check("ar_empty", int'(empty_op), 1);
    check("ar_err", int'(error_op), 0);
    #2 reset = 0;
    present(2, 1, 3, 1);
    check("ar_unpend", int'(stall_op), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_scoreboard.md
# id_scoreboard

Parametrised in-order register scoreboard for the decode stage. It records the destination register of every issued, not-yet-written-back instruction in a circular in-flight buffer. It blocks issue of any instruction whose sources read a pending register, supports flushing of the youngest in-flight entries on a redirect, and flags writeback-order errors. It sits between decode and the ID/EX buffer, and its stall output drives fetch and the ID/EX bubble insertion.

## Interface
- NUM_REGS, 32: architectural register count; register 0 is hard-wired zero.
- ADDR_WIDTH, 5: register address width, $clog2(NUM_REGS).
- DEPTH, 4: in-flight buffer entries, power of two, ≥2.
- WB_BYPASS, 1: 1 means the register file writes through, so a source matching the retiring entry is not a hazard that cycle.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- issue_valid_ip  in  1  decode holds a valid instruction.
- issue_src1_ip / issue_src2_ip  in  ADDR_WIDTH  source addresses.
- issue_src1_used_ip / issue_src2_used_ip  in  1  the instruction actually reads that source.
- issue_dest_ip  in  ADDR_WIDTH  destination address.
- issue_dest_we_ip  in  1  the instruction writes issue_dest_ip.
- issue_ready_op  out  1  the instruction may issue this cycle.
- stall_op  out  1  issue_valid_ip & ~issue_ready_op.
- stall_reason_op  out  sb_stall_e  SB_NONE / SB_RAW / SB_FULL / SB_FLUSH.
- retire_valid_ip  in  1  writeback of the oldest in-flight instruction.
- retire_addr_ip  in  ADDR_WIDTH  address being written back.
- flush_ip  in  1  kill younger in-flight entries.
- flush_keep_ip  in  $clog2(DEPTH+1)  number of oldest entries to keep.
- occupancy_op  out  $clog2(DEPTH+1)  live entries.
- full_op / empty_op  out  1  occupancy == DEPTH / == 0.
- error_op  out  1  sticky writeback-order violation.

## Operation
- **Storage.** Each entry holds {dest, we}, with head (oldest) and tail pointers modulo DEPTH plus an occupancy counter.
- **Push.** An issue handshake (issue_valid_ip & issue_ready_op) pushes {issue_dest_ip, issue_dest_we_ip & (issue_dest_ip != 0)} at tail. Every issued instruction occupies an entry, including instructions that do not write, so that retire order stays 1:1.
- **Pending.** Register r is pending if any live entry has we=1 and dest==r. Register 0 is never pending.
- **RAW hazard.** A hazard exists when a source has its used flag set and that source is pending. With WB_BYPASS=1 and retire_valid_ip asserted, the head entry is excluded from the compare.
- **issue_ready_op.** issue_ready_op = ~flush_ip & ~raw & (~full_op | retire_valid_ip).
- **stall_reason_op** is evaluated in priority order: SB_FLUSH when flush_ip, else SB_RAW when raw, else SB_FULL when full with no retire, else SB_NONE. It reads SB_NONE whenever issue_valid_ip=0.
- **Retire.** Retire pops the head entry. error_op sets if the buffer is empty, or if the head has we=1 and retire_addr_ip != head.dest. Only reset clears error_op.
- **Flush.** Flush applies after this cycle's retire:
  - occupancy becomes min(flush_keep_ip, occupancy_after_retire);
  - tail becomes head_after_retire + new occupancy;
  - no push occurs in a flush cycle.
- **Simultaneous issue and retire** leave occupancy unchanged, and both pointers advance.

## Timing
- **Reset values:** head = tail = 0, occupancy_op = 0, empty_op = 1, full_op = 0, error_op = 0. issue_ready_op = 1 with no flush. stall_op = 0 and stall_reason_op = SB_NONE while issue_valid_ip = 0.
- **Combinational paths:** issue_ready_op, stall_op and stall_reason_op are same-cycle functions of the inputs and the current state.
- **Registered state:** buffer, pointers, counters and error_op all update on the rising edge.
- **Pending visibility:** a pushed dest becomes pending from the next cycle onward. With WB_BYPASS=1, a retired dest stops blocking in its retire cycle. With WB_BYPASS=0, it stops blocking in the cycle after.
- **Reset mid-operation:** all entries are discarded immediately, and asynchronous assertion forces the reset values.
- **Pointer wrap:** pointers wrap modulo DEPTH. Occupancy saturates at neither end; instead, a push when full without a retire is impossible, because ready is 0 in that case.

## Structure
- **CORE_PKG additions:** the typedef sb_stall_e {SB_NONE, SB_RAW, SB_FULL, SB_FLUSH} and the function sb_occ_width(DEPTH).
- **Sub-module sb_pending_match:** a combinational DEPTH-way compare of one source against the live, we=1 entries, with an exclude-head input. It is instantiated twice, once per source.

## Test plan
- **Basic RAW stall:** issue ADDI x5 (dest 5, we). Next cycle, present ADD with src1=5 -> stall_op=1 and SB_RAW. retire_valid_ip=1 with addr 5 -> ready=1 in the same cycle (WB_BYPASS=1).
- **Register 0 and unused sources:** issue dest 0 with we=1, then src1=0 -> no stall. Pend x3, then present src2=3 with src2_used=0 -> no stall.
- **Full, then pass-through:** issue 4 non-dependent instructions -> full_op=1 and a fifth gets SB_FULL. Assert retire (addr matches head) -> fifth issues, occupancy stays 4.
- **Flush:** occupancy 3 with dests {1,2,3}; assert flush_ip with keep=1 -> occupancy 1 the next cycle, and src=2 and src=3 are no longer pending. Flush with retire and keep=1 in the same cycle -> occupancy 0.
- **Error detection:** retire when empty -> error_op=1 the next cycle and it stays set. Separately, head dest 4 retired with addr 6 -> error_op=1.
- **Asynchronous reset:** reset asserted mid-cycle with occupancy 3 -> occupancy_op=0, empty_op=1 and error_op=0 before the next edge, and the previously pending dests no longer stall.
